// File: rtl/sound_sequencer_if.sv
// Requester-side bundle for the sound sequencer: level requests with their
// tone parameters going in, grant pulses and tone-generator drive coming out.
interface sound_sequencer_if #(
    parameter int NREQ = 4
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]      req;
    logic [32*NREQ-1:0]   req_period;
    logic [16*NREQ-1:0]   req_dur;
    logic [NREQ-1:0]      ack;
    logic [31:0]          period;
    logic                 audEn;
    logic                 busy;
    logic [IW-1:0]        active_id;

    modport master (
        output req, req_period, req_dur,
        input  ack, period, audEn, busy, active_id
    );

    modport slave (
        input  req, req_period, req_dur,
        output ack, period, audEn, busy, active_id
    );
endinterface

// File: rtl/sound_sequencer.sv
// Fixed-priority note sequencer sharing one square-wave tone generator among
// NREQ requesters; higher-index requests preempt a playing note.
module sound_sequencer #(
    parameter int NREQ      = 4,
    parameter int TICK_DIV  = 100000,
    parameter int GAP_TICKS = 1
) (
    input  logic clock100,
    input  logic reset,
    sound_sequencer_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]   GAP_LOAD = 16'(GAP_TICKS);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t          state;
    logic [PW-1:0]   pre;
    logic [15:0]     cnt;
    logic [NREQ-1:0] ack_r;
    logic [31:0]     period_r;
    logic            aud_r;
    logic            busy_r;
    logic [IW-1:0]   id_r;

    logic            top_any;
    logic [IW-1:0]   top_id;
    logic            hi_any;
    logic [IW-1:0]   hi_id;
    logic            grant;
    logic [IW-1:0]   gid;

    function automatic logic [15:0] dur_floor(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

    function automatic logic [15:0] dec_floor(input logic [15:0] d);
        return (d == 16'd0) ? 16'd0 : d - 16'd1;
    endfunction

    // Ascending scan: the last hit is the highest-priority set index.
    always_comb begin
        top_any = 1'b0;
        top_id  = '0;
        hi_any  = 1'b0;
        hi_id   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req[i]) begin
                top_any = 1'b1;
                top_id  = IW'(i);
                if (i > int'(id_r)) begin
                    hi_any = 1'b1;
                    hi_id  = IW'(i);
                end
            end
        end
        grant = ((state == IDLE) && top_any) || ((state == PLAY) && hi_any);
        gid   = (state == IDLE) ? top_id : hi_id;
    end

    always_ff @(posedge clock100 or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pre      <= '0;
            cnt      <= '0;
            ack_r    <= '0;
            period_r <= '0;
            aud_r    <= 1'b0;
            busy_r   <= 1'b0;
            id_r     <= '0;
        end else begin
            ack_r <= '0;
            if (grant) begin
                period_r   <= bus.req_period[32*int'(gid) +: 32];
                id_r       <= gid;
                cnt        <= dur_floor(bus.req_dur[16*int'(gid) +: 16]);
                ack_r[gid] <= 1'b1;
                aud_r      <= 1'b1;
                busy_r     <= 1'b1;
                pre        <= '0;
                state      <= PLAY;
            end else begin
                case (state)
                    IDLE: begin
                        pre <= '0;
                    end
                    PLAY: begin
                        if (pre == PRE_LAST) begin
                            pre <= '0;
                            if (cnt <= 16'd1) begin
                                aud_r <= 1'b0;
                                if (GAP_TICKS > 0) begin
                                    cnt   <= GAP_LOAD;
                                    state <= GAP;
                                end else begin
                                    cnt    <= '0;
                                    busy_r <= 1'b0;
                                    state  <= IDLE;
                                end
                            end else begin
                                cnt <= dec_floor(cnt);
                            end
                        end else begin
                            pre <= pre + 1'b1;
                        end
                    end
                    GAP: begin
                        if (pre == PRE_LAST) begin
                            pre <= '0;
                            if (cnt <= 16'd1) begin
                                cnt    <= '0;
                                busy_r <= 1'b0;
                                state  <= IDLE;
                            end else begin
                                cnt <= dec_floor(cnt);
                            end
                        end else begin
                            pre <= pre + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ack       = ack_r;
    assign bus.period    = period_r;
    assign bus.audEn     = aud_r;
    assign bus.busy      = busy_r;
    assign bus.active_id = id_r;
endmodule
